// File: rtl/mem_access_ctrl.sv
// Sequenced MAR/MDR stage in front of the 256x32 RAM: SETUP/ACCESS/HOLD timing around a level-sensitive write.
// Optional address range trap enabled by defining MEM_ACCESS_CTRL_RANGE_CHECK_EN.
module mem_access_ctrl #(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  inout  wire  [DATA_W-1:0] mem_data,
  output logic [1:0]        o_dbg_state,
  output logic              o_dbg_bus_oe
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  localparam logic [3:0] LP_CNT_LOAD = 4'(WAIT_CYCLES - 1);

  generate
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
      $fatal(1, "mem_access_ctrl: WAIT_CYCLES must be in 1..15");
    end
  endgenerate

  state_t            r_state;
  logic [ADDR_W-1:0] r_mar;
  logic [DATA_W-1:0] r_mdr;
  logic [3:0]        r_cnt;
  logic              r_is_write;
  logic              r_range;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_bus_oe;
  logic              r_done;
  logic              r_err;
  logic              w_range_hit;
  logic              w_accept;

`ifdef MEM_ACCESS_CTRL_RANGE_CHECK_EN
  // The top address bit selects beyond the 256-word RAM.
  assign w_range_hit = addr_in[ADDR_W-1];
`else
  assign w_range_hit = 1'b0;
`endif

  assign w_accept = req_read | req_write;

  // Handshake: a request is taken only while idle (busy low); the requester holds off
  // until the single-cycle done pulse, which also qualifies rdata and err.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state     <= S_IDLE;
      r_mar       <= '0;
      r_mdr       <= '0;
      r_cnt       <= '0;
      r_is_write  <= 1'b0;
      r_range     <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_bus_oe    <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mar      <= addr_in;
            // Read wins when both requests arrive together.
            r_is_write <= ~req_read;
            r_range    <= w_range_hit;
            if (!req_read && !w_range_hit) begin
              r_mdr    <= wdata;
              r_bus_oe <= 1'b1;
            end
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_cnt <= LP_CNT_LOAD;
          if (r_range) begin
            r_state <= S_HOLD;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end else begin
            r_state     <= S_ACCESS;
            r_mem_read  <= ~r_is_write;
            r_mem_write <= r_is_write;
          end
        end
        S_ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_state     <= S_HOLD;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_done      <= 1'b1;
            if (!r_is_write) begin
              r_mdr <= mem_data;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_HOLD: begin
          // Bus stays driven through HOLD so data outlives the write strobe.
          r_state  <= S_IDLE;
          r_bus_oe <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_data     = r_bus_oe ? r_mdr : {DATA_W{1'bz}};
  assign rdata        = r_mdr;
  assign mem_addr     = r_mar;
  assign mem_read     = r_mem_read;
  assign mem_write    = r_mem_write;
  assign busy         = (r_state != S_IDLE);
  assign done         = r_done;
  assign err          = r_err;
  assign o_dbg_state  = r_state;
  assign o_dbg_bus_oe = r_bus_oe;

  a_strobe_excl: assert property (@(posedge clk) disable iff (clr)
    !(r_mem_read && r_mem_write));
  a_write_has_bus: assert property (@(posedge clk) disable iff (clr)
    r_mem_write |-> (r_bus_oe && $past(r_bus_oe)));
  a_bus_only_write: assert property (@(posedge clk) disable iff (clr)
    r_bus_oe |-> (!r_mem_read && r_state != S_IDLE));

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: instance a uses WAIT_CYCLES=1, instance b WAIT_CYCLES=3,
// both sharing one 256x32 RAM model.
module tb_mem_access_ctrl;

`ifdef MEM_ACCESS_CTRL_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic clk;
  int   errors;
  int   checks;

  logic        a_clr, a_req_read, a_req_write;
  logic [8:0]  a_addr_in;
  logic [31:0] a_wdata, a_rdata;
  logic        a_busy, a_done, a_err, a_mem_read, a_mem_write, a_oe;
  logic [8:0]  a_mem_addr;
  logic [1:0]  a_state;
  wire  [31:0] a_mem_data;

  logic        b_clr, b_req_read, b_req_write;
  logic [8:0]  b_addr_in;
  logic [31:0] b_wdata, b_rdata;
  logic        b_busy, b_done, b_err, b_mem_read, b_mem_write, b_oe;
  logic [8:0]  b_mem_addr;
  logic [1:0]  b_state;
  wire  [31:0] b_mem_data;

  logic [31:0] ram [0:255];
  logic        ram_load;
  logic [7:0]  ram_load_addr;
  logic [31:0] ram_load_data;

  mem_access_ctrl #(.WAIT_CYCLES(1)) u_a (
    .clk(clk), .clr(a_clr), .req_read(a_req_read), .req_write(a_req_write),
    .addr_in(a_addr_in), .wdata(a_wdata), .rdata(a_rdata), .busy(a_busy),
    .done(a_done), .err(a_err), .mem_addr(a_mem_addr), .mem_read(a_mem_read),
    .mem_write(a_mem_write), .mem_data(a_mem_data), .o_dbg_state(a_state),
    .o_dbg_bus_oe(a_oe)
  );

  mem_access_ctrl #(.WAIT_CYCLES(3)) u_b (
    .clk(clk), .clr(b_clr), .req_read(b_req_read), .req_write(b_req_write),
    .addr_in(b_addr_in), .wdata(b_wdata), .rdata(b_rdata), .busy(b_busy),
    .done(b_done), .err(b_err), .mem_addr(b_mem_addr), .mem_read(b_mem_read),
    .mem_write(b_mem_write), .mem_data(b_mem_data), .o_dbg_state(b_state),
    .o_dbg_bus_oe(b_oe)
  );

  // RAM model: drives the bus while read is high, latches while write is high.
  assign a_mem_data = a_mem_read ? ram[a_mem_addr[7:0]] : {32{1'bz}};
  assign b_mem_data = b_mem_read ? ram[b_mem_addr[7:0]] : {32{1'bz}};

  always @(posedge clk) begin
    if (ram_load)    ram[ram_load_addr]    <= ram_load_data;
    if (a_mem_write) ram[a_mem_addr[7:0]] <= a_mem_data;
    if (b_mem_write) ram[b_mem_addr[7:0]] <= b_mem_data;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_clr = 1'b1;
    b_clr = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a_req_read  = 1'($urandom_range(0, 1));
      a_req_write = 1'($urandom_range(0, 1));
      b_req_read  = 1'($urandom_range(0, 1));
      b_req_write = 1'($urandom_range(0, 1));
      a_addr_in   = 9'($urandom_range(0, 511));
      b_addr_in   = 9'($urandom_range(0, 511));
      a_wdata     = $urandom;
      b_wdata     = $urandom;
      tick();
      checks++;
      if ({a_mem_read, a_mem_write, a_busy, a_done, a_err, a_oe, a_state} !== 8'h00) begin
        errors++;
        $display("FAIL reset_a_ctrl cyc%0d: got rd=%b wr=%b busy=%b done=%b err=%b oe=%b st=%0d, want all 0",
                 i, a_mem_read, a_mem_write, a_busy, a_done, a_err, a_oe, a_state);
      end
      checks++;
      if ({a_rdata, a_mem_addr} !== 41'd0) begin
        errors++;
        $display("FAIL reset_a_regs cyc%0d: got rdata=%h addr=%h, want 0/0", i, a_rdata, a_mem_addr);
      end
      checks++;
      if ({b_mem_read, b_mem_write, b_busy, b_done, b_err, b_oe, b_state} !== 8'h00) begin
        errors++;
        $display("FAIL reset_b_ctrl cyc%0d: got rd=%b wr=%b busy=%b done=%b err=%b oe=%b st=%0d, want all 0",
                 i, b_mem_read, b_mem_write, b_busy, b_done, b_err, b_oe, b_state);
      end
      checks++;
      if ({b_rdata, b_mem_addr} !== 41'd0) begin
        errors++;
        $display("FAIL reset_b_regs cyc%0d: got rdata=%h addr=%h, want 0/0", i, b_rdata, b_mem_addr);
      end
    end
    a_clr = 1'b0; b_clr = 1'b0;
    a_req_read = 1'b0; a_req_write = 1'b0;
    b_req_read = 1'b0; b_req_write = 1'b0;
    tick();
  endtask

  // WAIT_CYCLES=1 write: cycles 1..3 = SETUP, ACCESS, HOLD after the accept edge.
  task automatic test_write_w1();
    int n_drv;
    int n_wr;
    n_drv = 0;
    n_wr  = 0;
    a_req_write = 1'b1;
    a_addr_in   = 9'h010;
    a_wdata     = 32'hDEADBEEF;
    for (int c = 1; c <= 4; c++) begin
      tick();
      a_req_write = 1'b0;
      if (a_oe) n_drv++;
      if (a_mem_write) n_wr++;
      checks++;
      if ({a_mem_write, a_oe, a_done, a_busy, a_err} !== {c == 2, c <= 3, c == 3, c <= 3, 1'b0}) begin
        errors++;
        $display("FAIL write_w1_ctrl c%0d: got wr=%b oe=%b done=%b busy=%b err=%b, want wr=%b oe=%b done=%b busy=%b err=0",
                 c, a_mem_write, a_oe, a_done, a_busy, a_err, c == 2, c <= 3, c == 3, c <= 3);
      end
      if (c <= 3) begin
        checks++;
        if (a_mem_data !== 32'hDEADBEEF || a_mem_addr !== 9'h010 || a_mem_read !== 1'b0) begin
          errors++;
          $display("FAIL write_w1_bus c%0d: got data=%h addr=%h rd=%b, want deadbeef/010/0",
                   c, a_mem_data, a_mem_addr, a_mem_read);
        end
      end
    end
    checks++;
    if (n_drv != 3 || n_wr != 1) begin
      errors++;
      $display("FAIL write_w1_counts: got drive=%0d write=%0d, want 3/1", n_drv, n_wr);
    end
    checks++;
    if (ram[8'h10] !== 32'hDEADBEEF || a_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_w1_ram: got ram=%h rdata=%h, want deadbeef", ram[8'h10], a_rdata);
    end
  endtask

  // WAIT_CYCLES=3 read: SETUP c1, ACCESS c2..c4, HOLD c5 with done.
  task automatic run_read_b(input logic [8:0] addr, input logic [31:0] exp_data,
                            input logic [31:0] old_data, input logic both, input string name);
    int n_rd;
    n_rd = 0;
    b_req_read  = 1'b1;
    b_req_write = both;
    b_addr_in   = addr;
    b_wdata     = 32'hCAFEF00D;
    for (int c = 1; c <= 6; c++) begin
      tick();
      b_req_read  = 1'b0;
      b_req_write = 1'b0;
      if (b_mem_read) n_rd++;
      checks++;
      if ({b_mem_read, b_mem_write, b_oe, b_done, b_busy} !==
          {(c >= 2 && c <= 4), 1'b0, 1'b0, c == 5, c <= 5}) begin
        errors++;
        $display("FAIL %s_ctrl c%0d: got rd=%b wr=%b oe=%b done=%b busy=%b, want rd=%b wr=0 oe=0 done=%b busy=%b",
                 name, c, b_mem_read, b_mem_write, b_oe, b_done, b_busy,
                 (c >= 2 && c <= 4), c == 5, c <= 5);
      end
      checks++;
      if (b_rdata !== ((c >= 5) ? exp_data : old_data)) begin
        errors++;
        $display("FAIL %s_rdata c%0d: got %h, want %h", name, c, b_rdata,
                 (c >= 5) ? exp_data : old_data);
      end
    end
    checks++;
    if (n_rd != 3) begin
      errors++;
      $display("FAIL %s_rdcount: got %0d, want 3", name, n_rd);
    end
  endtask

  task automatic test_read_w3();
    run_read_b(9'h010, 32'hDEADBEEF, 32'h0, 1'b0, "read_w3");
  endtask

  task automatic test_both_req();
    ram_load      = 1'b1;
    ram_load_addr = 8'h20;
    ram_load_data = 32'h12345678;
    tick();
    ram_load = 1'b0;
    run_read_b(9'h020, 32'h12345678, 32'hDEADBEEF, 1'b1, "both_req");
    checks++;
    if (ram[8'h20] !== 32'h12345678) begin
      errors++;
      $display("FAIL both_req_ram: got %h, want 12345678", ram[8'h20]);
    end
  endtask

  task automatic test_clr_mid_access();
    b_req_write = 1'b1;
    b_addr_in   = 9'h030;
    b_wdata     = 32'h0BADF00D;
    tick();
    b_req_write = 1'b0;
    tick();
    tick();
    checks++;
    if (b_mem_write !== 1'b1 || b_state !== 2'd2) begin
      errors++;
      $display("FAIL clr_pre: got wr=%b st=%0d, want 1/2", b_mem_write, b_state);
    end
    b_clr = 1'b1;
    tick();
    b_clr = 1'b0;
    checks++;
    if ({b_mem_read, b_mem_write, b_oe, b_done, b_busy, b_err, b_state} !== 8'h00 ||
        b_rdata !== 32'h0 || b_mem_addr !== 9'h0) begin
      errors++;
      $display("FAIL clr_after: got rd=%b wr=%b oe=%b done=%b busy=%b st=%0d rdata=%h addr=%h, want all 0",
               b_mem_read, b_mem_write, b_oe, b_done, b_busy, b_state, b_rdata, b_mem_addr);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (b_done !== 1'b0 || b_busy !== 1'b0) begin
        errors++;
        $display("FAIL clr_quiet c%0d: got done=%b busy=%b, want 0/0", c, b_done, b_busy);
      end
    end
    run_read_b(9'h020, 32'h12345678, 32'h0, 1'b0, "clr_then_read");
  endtask

  // Address 0x100: trapped when the range check is built in, otherwise a normal write.
  task automatic test_range();
    logic [31:0] exp_rdata;
    a_req_write = 1'b1;
    a_addr_in   = 9'h100;
    a_wdata     = 32'h55AA55AA;
    for (int c = 1; c <= 4; c++) begin
      tick();
      a_req_write = 1'b0;
      checks++;
      if (RANGE_EN) begin
        if ({a_mem_read, a_mem_write, a_oe, a_done, a_err, a_busy} !==
            {1'b0, 1'b0, 1'b0, c == 2, c == 2, c <= 2}) begin
          errors++;
          $display("FAIL range_on c%0d: got rd=%b wr=%b oe=%b done=%b err=%b busy=%b, want 0/0/0/%b/%b/%b",
                   c, a_mem_read, a_mem_write, a_oe, a_done, a_err, a_busy, c == 2, c == 2, c <= 2);
        end
      end else begin
        if ({a_mem_read, a_mem_write, a_oe, a_done, a_err, a_busy} !==
            {1'b0, c == 2, c <= 3, c == 3, 1'b0, c <= 3}) begin
          errors++;
          $display("FAIL range_off c%0d: got rd=%b wr=%b oe=%b done=%b err=%b busy=%b, want 0/%b/%b/%b/0/%b",
                   c, a_mem_read, a_mem_write, a_oe, a_done, a_err, a_busy, c == 2, c <= 3, c == 3, c <= 3);
        end
      end
      exp_rdata = RANGE_EN ? 32'hDEADBEEF : 32'h55AA55AA;
      checks++;
      if (a_rdata !== exp_rdata || a_mem_addr !== 9'h100) begin
        errors++;
        $display("FAIL range_regs c%0d: got rdata=%h addr=%h, want %h/100", c, a_rdata, a_mem_addr, exp_rdata);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Request held high across the whole access must only be taken once more after IDLE.
    int n_done;
    n_done = 0;
    a_req_read = 1'b1;
    a_addr_in  = 9'h010;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (a_done) n_done++;
      if (c == 4) begin
        checks++;
        if (a_busy !== 1'b0 || a_rdata !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL b2b_idle: got busy=%b rdata=%h, want 0/deadbeef", a_busy, a_rdata);
        end
      end
    end
    a_req_read = 1'b0;
    checks++;
    if (n_done != 2) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d, want 2", n_done);
    end
    tick();
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    a_clr = 1'b1; b_clr = 1'b1;
    a_req_read = 1'b0; a_req_write = 1'b0; a_addr_in = '0; a_wdata = '0;
    b_req_read = 1'b0; b_req_write = 1'b0; b_addr_in = '0; b_wdata = '0;
    ram_load = 1'b0; ram_load_addr = '0; ram_load_data = '0;
    test_reset();
    test_write_w1();
    test_read_w3();
    test_both_req();
    test_clr_mid_access();
    test_range();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
